// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register, req/ack imem handshake, one-word skid for decode stalls.
// Optional IF_PERF_CNT_EN adds saturating fetch_count / stall_count outputs.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        inst_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN} state_t;

  state_t      r_state, w_state;
  logic [31:0] r_pc, w_pc;
  logic [31:0] r_req_addr, w_req_addr;
  logic        r_req, w_req;
  logic [31:0] r_skid, w_skid;
  logic        r_skid_vld, w_skid_vld;
  logic [31:0] r_if_pc, r_if_instr;
  logic        r_if_vld;
  logic        w_ack, w_bubble, w_load, w_load_vld;
  logic [31:0] w_load_pc, w_load_instr;

  // ack is only meaningful while a request is outstanding
  assign w_ack = r_req & imem_ack;

  always_comb begin
    w_state      = r_state;
    w_pc         = r_pc;
    w_req_addr   = r_req_addr;
    w_req        = r_req;
    w_skid       = r_skid;
    w_skid_vld   = r_skid_vld;
    w_bubble     = 1'b0;
    w_load       = 1'b0;
    w_load_vld   = 1'b0;
    w_load_pc    = r_req_addr + 32'd4;
    w_load_instr = imem_rdata;
    case (r_state)
      S_IDLE: begin
        w_state    = S_FETCH;
        w_req_addr = r_pc;
        w_req      = 1'b1;
      end
      S_FETCH: begin
        if (flush && w_ack) begin
          w_bubble   = 1'b1;
          w_pc       = branch_addr;
          w_req_addr = branch_addr;
        end else if (flush) begin
          w_bubble = 1'b1;
          w_pc     = branch_addr;
          w_state  = S_DRAIN;
        end else if (w_ack && !freeze) begin
          w_load     = 1'b1;
          w_load_vld = 1'b1;
          w_pc       = r_req_addr + 32'd4;
          w_req_addr = r_req_addr + 32'd4;
        end else if (w_ack) begin
          w_skid     = imem_rdata;
          w_skid_vld = 1'b1;
          w_req      = 1'b0;
          w_state    = S_HOLD;
        end else if (!freeze) begin
          w_bubble = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush) begin
          w_skid_vld = 1'b0;
          w_bubble   = 1'b1;
          w_pc       = branch_addr;
          w_req_addr = branch_addr;
          w_req      = 1'b1;
          w_state    = S_FETCH;
        end else if (!freeze) begin
          w_load       = 1'b1;
          w_load_vld   = r_skid_vld;
          w_load_pc    = r_pc + 32'd4;
          w_load_instr = r_skid;
          w_skid_vld   = 1'b0;
          w_pc         = r_pc + 32'd4;
          w_req_addr   = r_pc + 32'd4;
          w_req        = 1'b1;
          w_state      = S_FETCH;
        end
      end
      S_DRAIN: begin
        // stale response is thrown away; a late flush just retargets pc
        if (flush) w_pc = branch_addr;
        if (w_ack) begin
          w_req_addr = flush ? branch_addr : r_pc;
          w_state    = S_FETCH;
        end
        if (flush || !freeze) w_bubble = 1'b1;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_req      <= 1'b0;
      r_skid     <= 32'h0;
      r_skid_vld <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_instr <= NOP_INSTR;
      r_if_vld   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_req_addr <= w_req_addr;
      r_req      <= w_req;
      r_skid     <= w_skid;
      r_skid_vld <= w_skid_vld;
      if (w_bubble) begin
        r_if_pc    <= 32'h0;
        r_if_instr <= NOP_INSTR;
        r_if_vld   <= 1'b0;
      end else if (w_load) begin
        r_if_pc    <= w_load_pc;
        r_if_instr <= w_load_instr;
        r_if_vld   <= w_load_vld;
      end
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_req_addr;
  assign PC          = r_if_pc;
  assign Instruction = r_if_instr;
  assign inst_valid  = r_if_vld;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt, r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt <= 32'h0;
      r_stall_cnt <= 32'h0;
    end else begin
      if (!w_bubble && w_load && w_load_vld && r_fetch_cnt != 32'hFFFF_FFFF)
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (r_req && !imem_ack && r_stall_cnt != 32'hFFFF_FFFF)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_count = r_fetch_cnt;
  assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory model returns word == address after a programmable latency.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC, Instruction;
  logic        inst_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int lat    = 0;
  int cnt    = 0;
  logic ack_r = 1'b0;

  if_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .branch_addr(branch_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .PC(PC), .Instruction(Instruction), .inst_valid(inst_valid)
`ifdef IF_PERF_CNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // lat==0: combinational ack; otherwise ack raised lat cycles into each request
  always @(negedge clk) begin
    if (!rst) begin
      cnt = 0; ack_r = 1'b0;
    end else if (ack_r) begin
      ack_r = 1'b0;
      cnt = imem_req ? 1 : 0;
    end else if (imem_req) begin
      cnt++;
      if (cnt >= lat) ack_r = 1'b1;
    end else begin
      cnt = 0;
    end
  end
  assign imem_ack   = (lat == 0) ? imem_req : ack_r;
  assign imem_rdata = imem_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins, input logic v);
    chk({tag, ".pc"}, PC, pc);
    chk({tag, ".ins"}, Instruction, ins);
    chk({tag, ".vld"}, {31'h0, inst_valid}, {31'h0, v});
  endtask

  // ends just after edge 1: FETCH at RESET_PC
  task automatic do_reset(input int l);
    rst = 1'b0; lat = l; freeze = 1'b0; flush = 1'b0;
    step(); step();
    rst = 1'b1; #1;
    chk("rel.req", {31'h0, imem_req}, 32'h0);
    step();
    chk("e1.req", {31'h0, imem_req}, 32'h1);
    chk("e1.addr", imem_addr, 32'h0);
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst.req", {31'h0, imem_req}, 32'h0);
    ifid("rst", 32'h0, 32'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
    chk("rst.fcnt", fetch_count, 32'h0);
    chk("rst.scnt", stall_count, 32'h0);
`endif

    // zero-wait streaming, then freeze while addr 8 is acked
    do_reset(0);
    ifid("e1", 32'h0, 32'h0, 1'b0);
    step(); ifid("zw0", 32'd4, 32'd0, 1'b1);
    step(); ifid("zw1", 32'd8, 32'd4, 1'b1);
    chk("zw1.addr", imem_addr, 32'd8);
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); ifid("frz", 32'd8, 32'd4, 1'b1);
      chk("frz.req", {31'h0, imem_req}, 32'h0);
    end
    freeze = 1'b0;
    step(); ifid("unfrz", 32'd12, 32'd8, 1'b1);
    chk("unfrz.req", {31'h0, imem_req}, 32'h1);
    chk("unfrz.addr", imem_addr, 32'd12);
    step(); ifid("zw2", 32'd16, 32'd12, 1'b1);

    // 3-cycle memory: valid one cycle in three, address steady during the wait
    do_reset(3);
    for (int k = 0; k < 9; k++) begin
      logic [31:0] a;
      a = 32'd4 * ((k + 1) / 3);
      step();
      if (k % 3 == 2) ifid("slow", a, a - 32'd4, 1'b1);
      else            ifid("slow", 32'h0, NOP_CONST(), 1'b0);
      chk("slow.addr", imem_addr, a);
    end
    step(); step(); step();
    ifid("slow16", 32'd16, 32'd12, 1'b1);

    // flush while 16 is pending: drain stale request, then fetch 0x100
    flush = 1'b1; branch_addr = 32'h100;
    step(); ifid("fl", 32'h0, 32'h0, 1'b0);
    chk("fl.addr", imem_addr, 32'd16);
    chk("fl.req", {31'h0, imem_req}, 32'h1);
    flush = 1'b0;
    step(); ifid("drain", 32'h0, 32'h0, 1'b0);
    chk("drain.addr", imem_addr, 32'd16);
    step(); ifid("drack", 32'h0, 32'h0, 1'b0);
    chk("drack.addr", imem_addr, 32'h100);
    step(); ifid("tgtw0", 32'h0, 32'h0, 1'b0);
    step(); ifid("tgtw1", 32'h0, 32'h0, 1'b0);
    step(); ifid("tgt", 32'h104, 32'h100, 1'b1);

    // flush + freeze in HOLD, then flush&ack in FETCH with address wrap
    do_reset(0);
    step(); ifid("h0", 32'd4, 32'd0, 1'b1);
    freeze = 1'b1;
    step(); chk("hold.req", {31'h0, imem_req}, 32'h0);
    ifid("hold", 32'd4, 32'd0, 1'b1);
    flush = 1'b1; branch_addr = 32'h200;
    step(); ifid("hfl", 32'h0, 32'h0, 1'b0);
    chk("hfl.req", {31'h0, imem_req}, 32'h1);
    chk("hfl.addr", imem_addr, 32'h200);
    flush = 1'b0; freeze = 1'b0;
    step(); ifid("hfl.t", 32'h204, 32'h200, 1'b1);
    flush = 1'b1; branch_addr = 32'hFFFF_FFFC;
    step(); ifid("fa", 32'h0, 32'h0, 1'b0);
    chk("fa.addr", imem_addr, 32'hFFFF_FFFC);
    flush = 1'b0;
    step(); ifid("wrap", 32'h0, 32'hFFFF_FFFC, 1'b1);
    chk("wrap.addr", imem_addr, 32'h0);

    // reset in the middle of the wait for addr 20
    do_reset(3);
    for (int k = 0; k < 16; k++) step();
    chk("mid.addr", imem_addr, 32'd20);
    ifid("mid", 32'h0, 32'h0, 1'b0);
    rst = 1'b0; #1;
    chk("mrst.req", {31'h0, imem_req}, 32'h0);
    chk("mrst.addr", imem_addr, 32'h0);
    ifid("mrst", 32'h0, 32'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
    chk("mrst.fcnt", fetch_count, 32'h0);
    chk("mrst.scnt", stall_count, 32'h0);
`endif
    do_reset(3);
    step(); step();
    ifid("re.w", 32'h0, 32'h0, 1'b0);
    step(); ifid("re", 32'd4, 32'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  function automatic logic [31:0] NOP_CONST();
    return 32'h0000_0000;
  endfunction
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage ARM-subset pipeline, including the IF/ID pipeline register. It owns the program counter and fetches from an instruction memory over a req/ack handshake that may take several cycles. It delivers instruction plus PC+4 to the decode stage, holding its output while decode reports a hazard. It redirects on a taken branch from execute, turning the in-flight slot into a bubble.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset
- NOP_INSTR, 32'h0000_0000, instruction word presented with a bubble
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- freeze  input  1  decode hazard; hold IF/ID register and PC
- flush  input  1  taken branch from execute; redirect to branch_addr
- branch_addr  input  32  branch target
- imem_req  output  1  fetch request, registered
- imem_addr  output  32  fetch address; stable while imem_req=1
- imem_ack  input  1  read data valid for the current request; sampled only while imem_req=1
- imem_rdata  input  32  instruction word, valid with imem_ack
- PC  output  32  IF/ID: address of fetched instruction + 4
- Instruction  output  32  IF/ID: instruction word, NOP_INSTR when invalid
- inst_valid  output  1  IF/ID holds a real instruction

## Operation
- Registers:
  - pc: next fetch address.
  - req_addr: drives imem_addr.
  - skid: 32-bit word plus valid.
  - IF/ID: PC, Instruction, inst_valid.
  - state.
- IDLE:
  - Entered on reset.
  - imem_req=0.
  - Next cycle: FETCH, with req_addr<=pc and imem_req<=1.
- FETCH: imem_req=1. Priority is top to bottom.
  - flush & ack:
    - Drop data.
    - pc<=branch_addr.
    - IF/ID<=bubble.
    - Stay FETCH, with req_addr<=branch_addr.
  - flush & !ack:
    - pc<=branch_addr.
    - IF/ID<=bubble.
    - Go DRAIN, keeping req_addr and imem_req=1.
  - ack & !freeze:
    - IF/ID<={req_addr+4, imem_rdata, 1}.
    - pc<=req_addr+4.
    - req_addr<=req_addr+4.
    - Stay FETCH.
  - ack & freeze:
    - skid<=imem_rdata.
    - IF/ID held.
    - imem_req<=0.
    - Go HOLD.
  - !ack & freeze: IF/ID held.
  - !ack & !freeze: IF/ID<=bubble.
- HOLD: imem_req=0.
  - flush:
    - Discard skid.
    - pc<=branch_addr.
    - IF/ID<=bubble.
    - Go FETCH at branch_addr.
  - !freeze:
    - IF/ID<={pc+4, skid, 1}.
    - pc<=pc+4.
    - Go FETCH at pc+4.
  - Otherwise: wait.
- DRAIN:
  - imem_req=1 at the stale req_addr until ack.
  - Response data is discarded.
  - On ack: go FETCH at pc.
  - A further flush in DRAIN only updates pc.
  - IF/ID<=bubble each cycle unless freeze.
- Bubble: {PC=32'h0, Instruction=NOP_INSTR, inst_valid=0}.
- flush overrides freeze everywhere.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
- Address bits [1:0] are passed through unchecked.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, pc=RESET_PC, req_addr=RESET_PC.
  - imem_req=0, skid invalid.
  - PC=0, Instruction=NOP_INSTR, inst_valid=0.
- After rst rises:
  - Edge 1: IDLE->FETCH; imem_req=1, imem_addr=RESET_PC.
  - Edge n: first ack sampled; instruction in IF/ID after that edge.
- Zero-wait memory (ack whenever req=1): one instruction per cycle; IF->ID latency 1 cycle after ack.
- Handshake rules:
  - imem_addr never changes while imem_req=1 and no ack has been sampled.
  - Exactly one ack is consumed per request.
- Freeze:
  - IF/ID outputs are bit-stable in every frozen cycle.
  - At most one word is fetched ahead; it is held in skid.
- Branch:
  - Target fetch begins the cycle after flush, or after the drain ack.
  - No instruction fetched before the redirect ever appears with inst_valid=1.
- Reset mid-request: the outstanding ack is lost. After reset, the memory must not assert ack until a new req is seen.

## Configuration
- IF_PERF_CNT_EN defined: adds two outputs, reset to 0 by rst and saturating at 32'hFFFF_FFFF.
  - fetch_count (output, 32): increments on each cycle IF/ID loads inst_valid=1.
  - stall_count (output, 32): increments on each cycle imem_req=1 & !imem_ack.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Zero-wait memory, word at addr = addr, RESET_PC=0:
  - After reset release, IF/ID shows {4,0,1}, {8,4,1}, {12,8,1} on consecutive cycles.
  - imem_req=0 during reset and the first cycle after.
- Ack 3 cycles after each req:
  - inst_valid pulses 1 cycle in 3.
  - Bubbles between pulses show NOP_INSTR.
  - imem_addr stable throughout each wait.
- freeze held 4 cycles while ack arrives for addr 8:
  - IF/ID holds {8,4,1} for 4 cycles; imem_req=0.
  - After release: {12,8,1}, then addr 12 is requested.
- flush with branch_addr=32'h100 while addr 16 is pending:
  - DRAIN keeps imem_addr=16 until ack; data dropped.
  - Next request is 32'h100.
  - No valid instruction from 16.
- flush and freeze together in HOLD:
  - Bubble loaded, skid discarded.
  - Fetch resumes at branch_addr.
- rst asserted mid-wait at addr 20:
  - All outputs go to reset values immediately.
  - Refetch starts at RESET_PC.
  - With IF_PERF_CNT_EN, both counters read 0.
